// File: rtl/bfloat16_mac2.sv
`default_nettype none
// ============================================================================
//  Module      : bfloat16_mac2
//  Description : Single-cycle fused bfloat16 multiply-accumulate (acc +/- a*b).
//                Define BF16_MAC_RNE_EN for round-to-nearest-even, else truncate.
//  Revision    : 1.0  initial release
// ============================================================================
module bfloat16_mac2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cntl,
    output logic [15:0] out
);
`ifdef BF16_MAC_RNE_EN
    localparam logic C_RNE = 1'b1;
`else
    localparam logic C_RNE = 1'b0;
`endif
    localparam logic [15:0] C_QNAN = 16'h7FC0;

    logic [15:0]        r_acc;
    logic               w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    logic               w_c_zero, w_c_inf, w_c_nan;
    logic               w_p_zero, w_p_inf, w_p_nan, w_p_sign;
    logic [15:0]        w_pm;
    logic signed [11:0] w_pe, w_ec, w_ep_eff, w_ec_eff, w_e_big, w_re, w_re_f;
    logic [31:0]        w_mp, w_mc, w_m_big, w_sml_raw, w_m_sml, w_mask;
    logic               w_p_big, w_s_big, w_s_sml, w_lost, w_sign;
    logic [11:0]        w_d;
    logic [32:0]        w_sum, w_norm;
    logic [5:0]         w_lead;
    logic               w_guard, w_sticky, w_inc;
    logic [8:0]         w_rnd;
    logic [6:0]         w_frac;
    logic [15:0]        w_finite, w_next;

    assign w_a_zero = (a[14:7] == 8'h00);
    assign w_a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
    assign w_a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
    assign w_b_zero = (b[14:7] == 8'h00);
    assign w_b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
    assign w_b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
    assign w_c_zero = (r_acc[14:7] == 8'h00);
    assign w_c_inf  = (r_acc[14:7] == 8'hFF) && (r_acc[6:0] == 7'h00);
    assign w_c_nan  = (r_acc[14:7] == 8'hFF) && (r_acc[6:0] != 7'h00);

    assign w_p_zero = w_a_zero | w_b_zero;
    assign w_p_inf  = w_a_inf | w_b_inf;
    assign w_p_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_p_sign = a[15] ^ b[15] ^ cntl;

    // Exact product; hidden-one weight sits at bit 14, carry into bit 15.
    assign w_pm = {8'h00, 1'b1, a[6:0]} * {8'h00, 1'b1, b[6:0]};
    assign w_pe = $signed({4'h0, a[14:7]}) + $signed({4'h0, b[14:7]}) - 12'sd127;
    assign w_ec = $signed({4'h0, r_acc[14:7]});

    // A zero operand borrows the other exponent so it never forces a shift.
    assign w_ep_eff = w_p_zero ? w_ec : w_pe;
    assign w_ec_eff = w_c_zero ? w_ep_eff : w_ec;
    assign w_mp     = w_p_zero ? 32'h0 : {w_pm, 16'h0000};
    assign w_mc     = w_c_zero ? 32'h0 : {2'b01, r_acc[6:0], 7'h00, 16'h0000};

    assign w_p_big   = (w_ep_eff >= w_ec_eff);
    assign w_e_big   = w_p_big ? w_ep_eff : w_ec_eff;
    assign w_d       = w_p_big ? w_ep_eff - w_ec_eff : w_ec_eff - w_ep_eff;
    assign w_m_big   = w_p_big ? w_mp : w_mc;
    assign w_sml_raw = w_p_big ? w_mc : w_mp;
    assign w_s_big   = w_p_big ? w_p_sign : r_acc[15];
    assign w_s_sml   = w_p_big ? r_acc[15] : w_p_sign;

    // Bits shifted past the 32-bit window collapse into a sticky LSB.
    assign w_mask  = 32'hFFFF_FFFF << w_d[4:0];
    assign w_lost  = (w_d > 12'd31) ? (|w_sml_raw) : (|(w_sml_raw & ~w_mask));
    assign w_m_sml = ((w_d > 12'd31) ? 32'h0 : (w_sml_raw >> w_d[4:0])) | {31'h0, w_lost};

    always_comb begin
        w_sum  = {1'b0, w_m_big} + {1'b0, w_m_sml};
        w_sign = w_s_big;
        if (w_s_big != w_s_sml) begin
            if (w_m_big >= w_m_sml) begin
                w_sum = {1'b0, w_m_big - w_m_sml};
            end else begin
                w_sum  = {1'b0, w_m_sml - w_m_big};
                w_sign = w_s_sml;
            end
        end
    end

    always_comb begin
        w_lead = 6'd0;
        for (int i = 0; i < 33; i++) begin
            if (w_sum[i]) w_lead = 6'(i);
        end
    end

    assign w_norm   = w_sum << (6'd32 - w_lead);
    assign w_re     = w_e_big + $signed({6'h00, w_lead}) - 12'sd30;
    assign w_guard  = w_norm[24];
    assign w_sticky = |w_norm[23:0];
    assign w_inc    = C_RNE & w_guard & (w_sticky | w_norm[25]);
    assign w_rnd    = {2'b01, w_norm[31:25]} + {8'h00, w_inc};
    assign w_frac   = w_rnd[8] ? 7'h00 : w_rnd[6:0];
    assign w_re_f   = w_re + $signed({11'h000, w_rnd[8]});

    // w_norm[32] is the normalised hidden one; it is clear only for a zero sum.
    always_comb begin
        if (!w_norm[32] || (w_re_f <= 12'sd0)) begin
            w_finite = 16'h0000;
        end else if (w_re_f >= 12'sd255) begin
            w_finite = {w_sign, 8'hFF, 7'h00};
        end else begin
            w_finite = {w_sign, w_re_f[7:0], w_frac};
        end
    end

    always_comb begin
        w_next = w_finite;
        if (w_c_nan || w_p_nan) begin
            w_next = C_QNAN;
        end else if (w_p_inf && w_c_inf && (w_p_sign != r_acc[15])) begin
            w_next = C_QNAN;
        end else if (w_p_inf) begin
            w_next = {w_p_sign, 8'hFF, 7'h00};
        end else if (w_c_inf) begin
            w_next = r_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 16'h0000;
        end else begin
            r_acc <= w_next;
        end
    end

    assign out = r_acc;
endmodule
`default_nettype wire

// File: tb/tb_bfloat16_mac2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bfloat16_mac2
//  Description : Directed-vector scoreboard bench for bfloat16_mac2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bfloat16_mac2;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a     = 16'h0000;
    logic [15:0] b     = 16'h0000;
    logic        cntl  = 1'b0;
    logic [15:0] out;

    logic [15:0] q_exp[$];
    int          q_id[$];
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          vec_id = 0;

`ifdef BF16_MAC_RNE_EN
    localparam logic [15:0] C_EXP_TIE_UP = 16'h3F81;
`else
    localparam logic [15:0] C_EXP_TIE_UP = 16'h3F80;
`endif

    always #5 clk = ~clk;

    bfloat16_mac2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cntl  (cntl),
        .out   (out)
    );

    task automatic check(input int id, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL vec%0d out=%h expected=%h", id, got, exp);
        end
    endtask

    // Monitor: the accumulator is presented after every rising edge.
    always begin
        @(posedge clk);
        #1;
        if (q_exp.size() > 0) begin
            check(q_id.pop_front(), out, q_exp.pop_front());
        end
    end

    task automatic step(input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic [15:0] exp);
        @(negedge clk);
        a    = ta;
        b    = tb;
        cntl = tc;
        vec_id++;
        q_exp.push_back(exp);
        q_id.push_back(vec_id);
    endtask

    task automatic do_reset();
        @(negedge clk);
        a     = 16'h0000;
        b     = 16'h0000;
        cntl  = 1'b0;
        rst_n = 1'b0;
        #1;
        vec_id++;
        check(vec_id, out, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired out=%h expected=finish", out);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check(0, out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        step(16'h0000, 16'h0000, 1'b0, 16'h0000);
        step(16'h0000, 16'h0000, 1'b0, 16'h0000);

        step(16'h3DCD, 16'h3F80, 1'b0, 16'h3DCD);
        step(16'h3F00, 16'h3F00, 1'b0, 16'h3EB3);
        step(16'hBDCD, 16'h3F00, 1'b0, 16'h3E99);

        do_reset();
        step(16'h3DCD, 16'h3F80, 1'b0, 16'h3DCD);
        step(16'h3DCD, 16'h3F80, 1'b1, 16'h0000);

        do_reset();
        step(16'h7F7F, 16'h3F80, 1'b0, 16'h7F7F);
        step(16'h7F7F, 16'h3F80, 1'b0, 16'h7F80);
        step(16'h3F80, 16'h3F80, 1'b0, 16'h7F80);
        step(16'hFF80, 16'h3F80, 1'b0, 16'h7FC0);
        step(16'h3F80, 16'h3F80, 1'b0, 16'h7FC0);

        do_reset();
        step(16'h3F80, 16'h3F80, 1'b0, 16'h3F80);
        step(16'h3B80, 16'h3F80, 1'b0, 16'h3F80);
        step(16'h3C00, 16'h3F80, 1'b0, 16'h3F81);
        step(16'h3C00, 16'h3F80, 1'b1, 16'h3F80);
        step(16'h3BC0, 16'h3F80, 1'b0, C_EXP_TIE_UP);

        do_reset();
        step(16'h3F80, 16'h3F80, 1'b1, 16'hBF80);
        step(16'h4000, 16'h3F80, 1'b0, 16'h3F80);
        step(16'h0001, 16'h3F80, 1'b0, 16'h3F80);
        step(16'h7F80, 16'h0000, 1'b0, 16'h7FC0);

        repeat (3) @(negedge clk);
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain pending=%0d expected=0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
